// File: rtl/span_margin_engine.sv
// rtl/span_margin_engine.sv - register-mapped SPAN initial-margin engine (scan risk, intermonth spread, margin)
// Legs are accumulated one per cycle, then scenarios scanned one per cycle, then results saturated into RO registers.
module span_margin_engine #(
    parameter int N_CONTRACTS = 8,
    parameter int N_SCEN      = 16,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] offset,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              irq
);
    localparam int AW = DATA_W + $clog2(N_CONTRACTS) + 1;
    localparam int PW = (N_CONTRACTS > 1) ? $clog2(N_CONTRACTS) : 1;
    localparam int SW = (N_SCEN > 1) ? $clog2(N_SCEN) : 1;
    localparam int CW = 5;
    localparam int LW = AW + 8 + DATA_W + 2;
    localparam int XW = AW + DATA_W;
    localparam logic [CW-1:0] ACC_LAST  = CW'(N_CONTRACTS - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(N_SCEN - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, SCAN, SUM, DONE} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0]        psr_q, spread_rate_q, margin_q, scan_risk_q, spread_chg_q, readData_q;
    logic signed [DATA_W-1:0] pos_q [N_CONTRACTS];
    logic signed [7:0]        move_q [N_SCEN];
    logic signed [AW-1:0]     net_q, long_q, short_q;
    logic signed [LW-1:0]     worst_q;
    logic [CW-1:0]            cnt_q;
    logic                     done_q, err_q;
    logic                     busy;

    logic                     bus_wr, bus_rd, pos_hit, move_hit, cfg_wr, start_ok;
    logic [PW-1:0]            pos_sel;
    logic [SW-1:0]            move_sel;
    logic [DATA_W-1:0]        rd_mux;

    assign bus_wr   = chipselect && write;
    assign bus_rd   = chipselect && read && !write;
    assign pos_sel  = offset[PW-1:0];
    assign move_sel = offset[SW-1:0];
    assign pos_hit  = (offset[ADDR_W-1:4] == (ADDR_W-4)'(1)) && ({1'b0, offset[3:0]} < 5'(N_CONTRACTS));
    assign move_hit = (offset[ADDR_W-1:4] == (ADDR_W-4)'(2)) && ({1'b0, offset[3:0]} < 5'(N_SCEN));
    assign cfg_wr   = bus_wr && (offset == ADDR_W'(1) || offset == ADDR_W'(2) || pos_hit || move_hit);
    // A start arriving in the DONE cycle is taken on the DONE -> ACCUM transition
    assign start_ok = bus_wr && (offset == '0) && writeData[0] && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start_ok ? ACCUM : IDLE;
            ACCUM:      if (cnt_q == ACC_LAST) state_d = SCAN;
            SCAN:       if (cnt_q == SCAN_LAST) state_d = SUM;
            SUM:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ACCUM) || (state_q == SCAN) || (state_q == SUM);
        irq  = (state_q == DONE);
    end

    logic signed [AW-1:0] leg_x, net_d, long_d, short_d;
    logic signed [LW-1:0] net_x, move_x, psr_x, prod, loss;
    logic [AW-1:0]        min_u;
    logic [XW-1:0]        spread_x;
    logic [DATA_W:0]      margin_sum;
    logic [DATA_W-1:0]    scan_risk_d, spread_chg_d, margin_d;

    always_comb begin
        leg_x   = pos_q[cnt_q[PW-1:0]];
        net_d   = net_q + leg_x;
        long_d  = (leg_x > 0) ? long_q + leg_x : long_q;
        short_d = (leg_x < 0) ? short_q - leg_x : short_q;

        net_x  = net_q;
        move_x = move_q[cnt_q[SW-1:0]];
        psr_x  = $signed(LW'(psr_q));
        prod   = net_x * move_x * psr_x;
        loss   = (-prod) >>> 3;

        scan_risk_d  = (|worst_q[LW-1:DATA_W]) ? '1 : worst_q[DATA_W-1:0];
        min_u        = (long_q < short_q) ? long_q : short_q;
        spread_x     = XW'(min_u) * XW'(spread_rate_q);
        spread_chg_d = (|spread_x[XW-1:DATA_W]) ? '1 : spread_x[DATA_W-1:0];
        margin_sum   = {1'b0, scan_risk_d} + {1'b0, spread_chg_d};
        margin_d     = margin_sum[DATA_W] ? '1 : margin_sum[DATA_W-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            ADDR_W'(0): rd_mux = DATA_W'({err_q, done_q, busy});
            ADDR_W'(1): rd_mux = psr_q;
            ADDR_W'(2): rd_mux = spread_rate_q;
            ADDR_W'(3): rd_mux = margin_q;
            ADDR_W'(4): rd_mux = scan_risk_q;
            ADDR_W'(5): rd_mux = spread_chg_q;
            default: begin
                if (pos_hit)
                    rd_mux = pos_q[pos_sel];
                else if (move_hit)
                    rd_mux = {{(DATA_W-8){move_q[move_sel][7]}}, move_q[move_sel]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            psr_q         <= '0;
            spread_rate_q <= '0;
            margin_q      <= '0;
            scan_risk_q   <= '0;
            spread_chg_q  <= '0;
            readData_q    <= '0;
            net_q         <= '0;
            long_q        <= '0;
            short_q       <= '0;
            worst_q       <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < N_CONTRACTS; i++) pos_q[i] <= '0;
            for (int s = 0; s < N_SCEN; s++) move_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (bus_rd) readData_q <= rd_mux;

            if (start_ok) begin
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                net_q   <= '0;
                long_q  <= '0;
                short_q <= '0;
                worst_q <= '0;
                cnt_q   <= '0;
            end

            // Parameter writes during a pass would corrupt it, so they are dropped and flagged
            if (cfg_wr && busy) begin
                err_q <= 1'b1;
            end else if (bus_wr) begin
                if (offset == ADDR_W'(1)) psr_q <= writeData;
                if (offset == ADDR_W'(2)) spread_rate_q <= writeData;
                if (pos_hit) pos_q[pos_sel] <= writeData;
                if (move_hit) move_q[move_sel] <= writeData[7:0];
            end

            case (state_q)
                ACCUM: begin
                    net_q   <= net_d;
                    long_q  <= long_d;
                    short_q <= short_d;
                    cnt_q   <= (cnt_q == ACC_LAST) ? '0 : cnt_q + 1'b1;
                end
                SCAN: begin
                    if (loss > worst_q) worst_q <= loss;
                    cnt_q <= (cnt_q == SCAN_LAST) ? '0 : cnt_q + 1'b1;
                end
                SUM: begin
                    scan_risk_q  <= scan_risk_d;
                    spread_chg_q <= spread_chg_d;
                    margin_q     <= margin_d;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign readData = readData_q;

endmodule
